// File: rtl/fir_cfg_master.sv
// fir_cfg_master: AXI4-Lite initiator that programs the fir taps and
// data_length, verifies the taps by readback, then launches the core
// and waits for ap_done. One transaction is outstanding at a time.
// pPOLL_GAP is expected to be at least 1.
module fir_cfg_master #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int pPOLL_GAP   = 4,
  parameter int pTIMEOUT    = 4096
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cmd_start,
  input  logic [pDATA_WIDTH-1:0] cmd_len,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             err,
  output logic                   coef_EN,
  output logic [pADDR_WIDTH-1:0] coef_A,
  input  logic [pDATA_WIDTH-1:0] coef_Do,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rready
);
  localparam int IW = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
  localparam int PW = $clog2(pTIMEOUT + 1);
  localparam int GW = (pPOLL_GAP > 0) ? $clog2(pPOLL_GAP + 1) : 1;

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(32'h00);
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TAP  = pADDR_WIDTH'(32'h20);

  // CAP states are the second cycle of a BRAM fetch, where coef_Do is valid.
  typedef enum logic [3:0] {
    S_IDLE, S_POLL_IDLE, S_GAP_IDLE, S_FETCH, S_CAP, S_WR_TAP, S_WR_LEN,
    S_CHK_FETCH, S_CHK_CAP, S_RD_TAP, S_WR_START, S_POLL_DONE, S_GAP_DONE, S_FIN
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]          idx;
  logic [PW-1:0]          poll_cnt;
  logic [GW-1:0]          gap_cnt;
  logic [pDATA_WIDTH-1:0] len_q, coef_q;
  logic                   aw_ok, w_ok, rd_ph;

  logic wr_act, rd_act, aw_hit, w_hit, wr_done, rd_done;
  logic last, poll_last, poll_hit, gap_end;
  logic [pADDR_WIDTH-1:0] idx_off, wr_addr, rd_addr;
  logic [pDATA_WIDTH-1:0] wr_data;

  assign idx_off   = pADDR_WIDTH'({idx, 2'b00});
  assign last      = (idx == IW'(Tape_Num - 1));
  assign poll_last = (poll_cnt == PW'(pTIMEOUT - 1));
  assign gap_end   = (gap_cnt == GW'(pPOLL_GAP - 1));
  assign poll_hit  = (state == S_POLL_IDLE) ? rdata[2] : rdata[1];

  // A start write is skipped entirely once a tap mismatch has been seen.
  assign wr_act  = (state == S_WR_TAP) || (state == S_WR_LEN) ||
                   ((state == S_WR_START) && !err[0]);
  assign rd_act  = (state == S_POLL_IDLE) || (state == S_RD_TAP) || (state == S_POLL_DONE);
  assign aw_hit  = aw_ok || (awvalid && awready);
  assign w_hit   = w_ok  || (wvalid  && wready);
  assign wr_done = wr_act && aw_hit && w_hit;
  assign rd_done = rready && rvalid;

  assign awvalid = wr_act && !aw_ok;
  assign wvalid  = wr_act && !w_ok;
  assign awaddr  = wr_act ? wr_addr : '0;
  assign wdata   = wr_act ? wr_data : '0;
  assign arvalid = rd_act && !rd_ph;
  assign rready  = rd_act && rd_ph;
  assign araddr  = rd_act ? rd_addr : '0;
  assign coef_EN = (state == S_FETCH) || (state == S_CHK_FETCH);
  assign coef_A  = coef_EN ? idx_off : '0;
  assign busy    = (state != S_IDLE) && (state != S_FIN);
  assign done    = (state == S_FIN);

  // Address/data of the transaction owned by the current state; held
  // constant for the whole state so they stay stable while valid.
  always_comb begin
    wr_addr = ADDR_CTRL;
    wr_data = '0;
    rd_addr = ADDR_CTRL;
    case (state)
      S_WR_TAP:   begin wr_addr = ADDR_TAP + idx_off; wr_data = coef_q; end
      S_WR_LEN:   begin wr_addr = ADDR_LEN; wr_data = len_q; end
      S_WR_START: wr_data = pDATA_WIDTH'(1);
      S_RD_TAP:   rd_addr = ADDR_TAP + idx_off;
      default:    ;
    endcase
  end

  // State register.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state <= S_IDLE;
    else             state <= state_nx;
  end

  // Sequencing of the configure / check / launch flow.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (cmd_start) state_nx = S_POLL_IDLE;
      S_POLL_IDLE: if (rd_done) state_nx = poll_hit ? S_FETCH : (poll_last ? S_FIN : S_GAP_IDLE);
      S_GAP_IDLE:  if (gap_end) state_nx = S_POLL_IDLE;
      S_FETCH:     state_nx = S_CAP;
      S_CAP:       state_nx = S_WR_TAP;
      S_WR_TAP:    if (wr_done) state_nx = last ? S_WR_LEN : S_FETCH;
      S_WR_LEN:    if (wr_done) state_nx = S_CHK_FETCH;
      S_CHK_FETCH: state_nx = S_CHK_CAP;
      S_CHK_CAP:   state_nx = S_RD_TAP;
      S_RD_TAP:    if (rd_done) state_nx = last ? S_WR_START : S_CHK_FETCH;
      S_WR_START:  if (err[0]) state_nx = S_FIN;
                   else if (wr_done) state_nx = S_POLL_DONE;
      S_POLL_DONE: if (rd_done) state_nx = (poll_hit || poll_last) ? S_FIN : S_GAP_DONE;
      S_GAP_DONE:  if (gap_end) state_nx = S_POLL_DONE;
      S_FIN:       state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Handshake flags, index/poll counters, captured operands and status.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      idx      <= '0;
      poll_cnt <= '0;
      gap_cnt  <= '0;
      len_q    <= '0;
      coef_q   <= '0;
      aw_ok    <= 1'b0;
      w_ok     <= 1'b0;
      rd_ph    <= 1'b0;
      err      <= 2'd0;
    end else begin
      if (wr_done) begin
        aw_ok <= 1'b0;
        w_ok  <= 1'b0;
      end else if (wr_act) begin
        aw_ok <= aw_hit;
        w_ok  <= w_hit;
      end
      if (rd_done)                rd_ph <= 1'b0;
      else if (arvalid && arready) rd_ph <= 1'b1;
      gap_cnt <= ((state == S_GAP_IDLE) || (state == S_GAP_DONE)) ? gap_cnt + 1'b1 : '0;
      case (state)
        S_IDLE: if (cmd_start) begin
          len_q    <= cmd_len;
          err      <= 2'd0;
          idx      <= '0;
          poll_cnt <= '0;
        end
        S_POLL_IDLE, S_POLL_DONE: if (rd_done) begin
          poll_cnt <= poll_cnt + 1'b1;
          if (poll_hit)       idx <= '0;
          else if (poll_last) err <= 2'd2;
        end
        S_CAP, S_CHK_CAP: coef_q <= coef_Do;
        S_WR_TAP: if (wr_done) idx <= last ? '0 : idx + 1'b1;
        S_RD_TAP: if (rd_done) begin
          if (rdata != coef_q) err <= 2'd1;
          idx <= last ? '0 : idx + 1'b1;
        end
        S_WR_START: if (wr_done) poll_cnt <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_cfg_master.sv
// tb_fir_cfg_master: drives fir_cfg_master against a behavioural fir
// AXI-Lite target and coefficient BRAM; expected writes/reads are queued
// when a sequence is launched and checked as the DUT issues them.
module tb_fir_cfg_master;
  localparam int NT = 11;
  localparam int TMO = 8;
  localparam int DONE_DLY = 20;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        cmd_start;
  logic [31:0] cmd_len;
  logic        busy, done;
  logic [1:0]  err;
  logic        coef_EN;
  logic [11:0] coef_A;
  logic [31:0] coef_Do;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;

  fir_cfg_master #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(NT),
                   .pPOLL_GAP(4), .pTIMEOUT(TMO)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .cmd_start(cmd_start), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err), .coef_EN(coef_EN), .coef_A(coef_A), .coef_Do(coef_Do),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready), .wvalid(wvalid), .wdata(wdata),
    .wready(wready), .arvalid(arvalid), .araddr(araddr), .arready(arready), .rvalid(rvalid),
    .rdata(rdata), .rready(rready));

  always #5 axis_clk = ~axis_clk;

  typedef struct { bit wr; logic [11:0] addr; logic [31:0] data; } txn_t;
  txn_t sb[$];

  int n_vec = 0, n_err = 0;

  // target / BRAM model state
  int          taps[NT];
  logic [31:0] tap_reg[NT];
  logic [31:0] len_reg;
  bit          ap_idle, ap_done;
  int          start_tmr;
  int          aw_dly, w_dly, corrupt;
  bit          hold0;
  int          rd00;
  int          aw_wait, w_wait;
  bit          aw_pend, w_pend, ar_pend, r_take, aw_held, w_held;
  logic [11:0] aw_a, aw_hold;
  logic [31:0] w_d, w_hold, rd_val, bram_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input bit wr, input logic [11:0] a, input logic [31:0] d);
    txn_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("txn_kind", 32'(wr), 32'(e.wr));
      chk("txn_addr", 32'(a), 32'(e.addr));
      if (wr) chk("txn_wdata", d, e.data);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    sb_pop(1'b1, a, d);
    if (a == 12'h000 && d[0]) begin
      ap_idle = 1'b0; ap_done = 1'b0; start_tmr = DONE_DLY;
    end else if (a == 12'h010) len_reg = d;
    else if (a >= 12'h020 && a < 12'h020 + 12'(4 * NT)) tap_reg[(a - 12'h020) >> 2] = d;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] v);
    int k;
    v = '0;
    if (a == 12'h000) begin
      rd00++;
      v = {29'd0, ap_idle & ~hold0, ap_done, 1'b0};
    end else begin
      sb_pop(1'b0, a, '0);
      if (a == 12'h010) v = len_reg;
      else if (a >= 12'h020 && a < 12'h020 + 12'(4 * NT)) begin
        k = int'((a - 12'h020) >> 2);
        v = tap_reg[k] ^ ((k == corrupt) ? 32'd1 : 32'd0);
      end
    end
  endtask

  // Target + BRAM model, evaluated mid-cycle so decisions apply at the next edge.
  initial begin
    awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0; coef_Do = '0; bram_q = '0;
    aw_wait = 0; w_wait = 0; aw_pend = 0; w_pend = 0; ar_pend = 0; r_take = 0;
    aw_held = 0; w_held = 0; start_tmr = 0;
    forever begin
      @(negedge axis_clk);
      if (!axis_rst_n) begin
        awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0;
        aw_wait = 0; w_wait = 0; aw_pend = 0; w_pend = 0; ar_pend = 0; r_take = 0;
        aw_held = 0; w_held = 0;
        continue;
      end
      coef_Do = bram_q;
      if (coef_EN) bram_q = taps[coef_A[11:2]];
      if (start_tmr > 0) begin
        start_tmr--;
        if (start_tmr == 0) begin ap_done = 1'b1; ap_idle = 1'b1; end
      end
      // write address channel
      if (awvalid) begin
        if (aw_held) chk("awaddr_stable", 32'(awaddr), 32'(aw_hold));
        else begin aw_held = 1; aw_hold = awaddr; end
        aw_wait++;
        awready = (aw_wait > aw_dly);
      end else begin aw_wait = 0; awready = 0; aw_held = 0; end
      if (awready) begin
        chk("aw_single", 32'(aw_pend), 32'd0);
        aw_pend = 1; aw_a = awaddr; aw_wait = 0; aw_held = 0;
      end
      // write data channel
      if (wvalid) begin
        if (w_held) chk("wdata_stable", wdata, w_hold);
        else begin w_held = 1; w_hold = wdata; end
        w_wait++;
        wready = (w_wait > w_dly);
      end else begin w_wait = 0; wready = 0; w_held = 0; end
      if (wready) begin
        chk("w_single", 32'(w_pend), 32'd0);
        w_pend = 1; w_d = wdata; w_wait = 0; w_held = 0;
      end
      if (aw_pend && w_pend) begin
        do_write(aw_a, w_d);
        aw_pend = 0; w_pend = 0;
      end
      // read channels
      if (rvalid && r_take) begin rvalid = 0; rdata = '0; end
      if (ar_pend) begin rvalid = 1; rdata = rd_val; ar_pend = 0; end
      r_take = rvalid && rready;
      arready = arvalid && !rvalid && !ar_pend;
      if (arready) begin ar_pend = 1; do_read(araddr, rd_val); end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ctl_outs();
    return 32'({busy, done, err, awvalid, wvalid, arvalid, rready, coef_EN});
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, ctl_outs(), 32'd0);
    chk({tag, "_addr"}, 32'({awaddr, araddr}), 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_coefA"}, 32'(coef_A), 32'd0);
  endtask

  task automatic tgt_setup(input int awd, input int wd, input int cor, input bit h0, input bit rnd);
    aw_dly = awd; w_dly = wd; corrupt = cor; hold0 = h0;
    for (int k = 0; k < NT; k++) tap_reg[k] = '0;
    len_reg = '0; ap_idle = 1'b1; ap_done = 1'b0; start_tmr = 0; rd00 = 0;
    taps = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    if (rnd) for (int k = 0; k < NT; k++) taps[k] = int'($urandom);
  endtask

  task automatic push_expected(input logic [31:0] len, input bit with_start);
    for (int k = 0; k < NT; k++) sb.push_back('{1'b1, 12'(12'h020 + 4 * k), 32'(taps[k])});
    sb.push_back('{1'b1, 12'h010, len});
    for (int k = 0; k < NT; k++) sb.push_back('{1'b0, 12'(12'h020 + 4 * k), 32'd0});
    if (with_start) sb.push_back('{1'b1, 12'h000, 32'd1});
  endtask

  task automatic launch(input logic [31:0] len);
    @(negedge axis_clk);
    cmd_start = 1'b1; cmd_len = len;
    @(negedge axis_clk);
    cmd_start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic run_case(input string name, input int awd, input int wd, input int cor,
                          input bit h0, input bit rnd, input logic [31:0] len,
                          input logic [1:0] exp_err, input bit poke);
    bit got;
    tgt_setup(awd, wd, cor, h0, rnd);
    if (!h0) push_expected(len, exp_err == 2'd0);
    launch(len);
    if (poke) begin
      repeat (30) @(negedge axis_clk);
      cmd_start = 1'b1; cmd_len = len + 32'd1;
      @(negedge axis_clk);
      cmd_start = 1'b0;
    end
    got = 0;
    for (int c = 0; c < 4000; c++) begin
      if (done) begin got = 1; break; end
      @(negedge axis_clk);
    end
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({name, "_err"}, 32'(err), 32'(exp_err));
      chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({name, "_sb_left"}, 32'(sb.size()), 32'd0);
      if (exp_err == 2'd0) chk({name, "_ap_done_first"}, 32'(ap_done), 32'd1);
      if (h0) chk({name, "_idle_polls"}, 32'(rd00), 32'(TMO));
      @(negedge axis_clk);
      chk({name, "_done_pulse"}, 32'(done), 32'd0);
      chk({name, "_busy_after"}, 32'(busy), 32'd0);
    end
    sb.delete();
    repeat (3) @(negedge axis_clk);
  endtask

  initial begin
    bit hit;
    axis_rst_n = 1'b0; cmd_start = 1'b0; cmd_len = '0;
    tgt_setup(0, 0, -1, 0, 0);
    repeat (3) @(negedge axis_clk);
    check_all_zero("reset");
    axis_rst_n = 1'b1;
    repeat (2) @(negedge axis_clk);

    run_case("ideal",    0, 0, -1, 0, 0, 32'd600,  2'd0, 0);
    run_case("bp",       3, 1, -1, 0, 1, 32'd1234, 2'd0, 1);
    run_case("w_first",  3, 0, -1, 0, 1, 32'd77,   2'd0, 0);
    run_case("aw_first", 0, 3, -1, 0, 1, 32'd9,    2'd0, 0);
    run_case("mismatch", 0, 0,  5, 0, 0, 32'd600,  2'd1, 0);
    run_case("timeout",  0, 0, -1, 1, 0, 32'd600,  2'd2, 0);

    // Abort a sequence while tap 4 is being written, then restart cleanly.
    tgt_setup(3, 0, -1, 0, 0);
    push_expected(32'd600, 1'b1);
    launch(32'd600);
    hit = 0;
    for (int c = 0; c < 2000; c++) begin
      if (awvalid && awaddr == 12'h030) begin hit = 1; break; end
      @(negedge axis_clk);
    end
    chk("reach_tap4", 32'(hit), 32'd1);
    axis_rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge axis_clk);
    check_all_zero("mid_reset_edge");
    sb.delete();
    axis_rst_n = 1'b1;
    repeat (2) @(negedge axis_clk);
    run_case("restart", 1, 2, -1, 0, 0, 32'd600, 2'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fir_cfg_master.md
Name: fir_cfg_master

Overview:
- AXI4-Lite initiator that configures and launches the fir block.
- Sequence: wait for FIR idle → write Tape_Num coefficients from a local coefficient BRAM → write data_length → read back and check taps → set ap_start → poll ap_done.
- Sits between the host/test sequencer and the fir AXI-Lite target; the stream path is not touched.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite and coefficient-BRAM address width
- pDATA_WIDTH, 32, data width
- Tape_Num, 11, number of taps to program and check
- pPOLL_GAP, 4, idle cycles between consecutive status reads
- pTIMEOUT, 4096, maximum status polls per wait phase before error

Ports:
- axis_clk  in  1  clock
- axis_rst_n  in  1  asynchronous active-low reset
- cmd_start  in  1  start pulse; sampled only in IDLE
- cmd_len  in  32  data_length value to program
- busy  out  1  high from accepted cmd_start until DONE exit
- done  out  1  one-cycle pulse at sequence end
- err  out  2  0 = ok, 1 = tap readback mismatch, 2 = timeout; valid with done
- coef_EN  out  1  coefficient BRAM enable
- coef_A  out  12  coefficient BRAM byte address
- coef_Do  in  32  coefficient BRAM read data, 1-cycle latency
- awvalid  out  1  write address valid
- awaddr  out  12  write address
- awready  in  1  write address ready
- wvalid  out  1  write data valid
- wdata  out  32  write data
- wready  in  1  write data ready
- arvalid  out  1  read address valid
- araddr  out  12  read address
- arready  in  1  read address ready
- rvalid  in  1  read data valid
- rdata  in  32  read data
- rready  out  1  read data ready

Behaviour:
- Target register map:
  - 0x00 ap_ctrl: bit0 ap_start (W), bit1 ap_done (R), bit2 ap_idle (R).
  - 0x10 data_length.
  - 0x20+4*i tap i, for i = 0..Tape_Num-1.
- Reset values: all outputs 0, err = 0, state IDLE, index counter i = 0.
- Write transaction:
  - awvalid and wvalid rise together.
  - Each stays high until its own ready is seen; track aw_ok and w_ok flags.
  - The write completes in the cycle both flags are set (including both handshakes in the same cycle).
  - There is no B channel.
  - awaddr and wdata stay stable while valid is high.
- Read transaction:
  - arvalid stays high until arready.
  - rready goes high the cycle after the AR handshake.
  - Data is taken on rvalid&rready; rready then drops.
  - Only one outstanding transaction at a time.
- States:
  - IDLE: on cmd_start, latch cmd_len, set busy → POLL_IDLE.
  - POLL_IDLE: read 0x00.
    - bit2 = 1 → FETCH, i = 0.
    - Otherwise wait pPOLL_GAP cycles and re-read.
    - After pTIMEOUT polls → err = 2, go to FIN.
  - FETCH: coef_EN = 1, coef_A = 4*i; capture coef_Do next cycle → WR_TAP.
  - WR_TAP: write coef to 0x20+4*i.
    - On completion: if i == Tape_Num-1 → WR_LEN with i = 0; else i+1 → FETCH.
  - WR_LEN: write latched length to 0x10 → CHK_FETCH.
  - CHK_FETCH / RD_TAP: re-fetch coef i, read 0x20+4*i, compare full 32 bits.
    - On mismatch: set err = 1 (sticky), continue checking.
    - Last index → WR_START.
  - WR_START:
    - If err = 1: skip the start write → FIN.
    - Otherwise write 0x00 = 0x1 → POLL_DONE.
  - POLL_DONE: read 0x00 until bit1 = 1 → FIN; same gap and timeout rules as POLL_IDLE (err = 2).
  - FIN: done = 1 for one cycle, busy = 0 → IDLE.
- cmd_start while busy is ignored.
- The poll counter resets on entry to each poll state.
- Reset mid-transaction: all valids drop immediately and the sequence is abandoned; no recovery or retry.

Test Plan:
- Ideal target (ready always 1), taps {0,-10,-9,23,56,63,56,23,-9,-10,0}, cmd_len = 600:
  - Writes in order 0x20..0x48, then 0x10 = 600, 11 reads, then 0x00 = 1.
  - done pulses after ap_done is seen, with err = 0.
- Backpressure: awready delayed 3 cycles and wready delayed 1 → awaddr/wdata held stable, exactly one write per register.
- Separated handshakes: wready asserted before awready and vice versa → write completes only when both are seen; no duplicate transaction.
- Mismatch: target corrupts tap 5 on readback → err = 1, no write to 0x00, done pulses, busy then low.
- Timeout: ap_idle held at 0 with pTIMEOUT = 8 → exactly 8 reads of 0x00, err = 2, done pulse, no tap writes.
- Reset asserted during WR_TAP with i = 4 → all outputs 0 on the next edge; a fresh cmd_start restarts from tap 0.
